// File: rtl/battleship_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// battleship_pkg: shared state/result/winner encodings and widths
// Revision: 1.0
// ------------------------------------------------------------------
package battleship_pkg;

   localparam int COORD_W = 4;
   localparam int HIT_W   = 7;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_SHOT = 3'd1,
      ST_SCORE     = 3'd2,
      ST_REPORT    = 3'd3,
      ST_GAME_OVER = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      RES_MISS  = 2'b00,
      RES_NEAR  = 2'b01,
      RES_HIT   = 2'b10,
      RES_WRONG = 2'b11
   } result_e;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P0   = 2'b01;
   localparam logic [1:0] WIN_P1   = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   // Wrong beats everything, Hit beats Miss; no flag at all reads as a Miss.
   function automatic result_e classify(input logic hit, input logic near, input logic wrong);
      if (wrong)
         return RES_WRONG;
      else if (hit)
         return RES_HIT;
      else if (near)
         return RES_NEAR;
      else
         return RES_MISS;
   endfunction

endpackage
`default_nettype wire

// File: rtl/battleship_player_budget.sv
`default_nettype none
// ------------------------------------------------------------------
// battleship_player_budget: one player's shots, big shots and hit count
// Revision: 1.0
// ------------------------------------------------------------------
module battleship_player_budget
   import battleship_pkg::*;
#(
   parameter int SHOTS_PER_PLAYER = 20,
   parameter int BIG_SHOTS        = 3
) (
   input  logic             clock,
   input  logic             reset_N,
   input  logic             load,
   input  logic             consume,
   input  logic             big,
   input  logic             hit,
   output logic             zero,
   output logic             zero_nxt,
   output logic [1:0]       big_left,
   output logic [HIT_W-1:0] hits,
   output logic [HIT_W-1:0] hits_nxt
);

   localparam int                SHOT_W       = $clog2(SHOTS_PER_PLAYER + 1);
   localparam logic [SHOT_W-1:0] c_shots_init = SHOT_W'(SHOTS_PER_PLAYER);
   localparam logic [1:0]        c_big_init   = 2'(BIG_SHOTS);
   localparam logic [HIT_W-1:0]  c_hits_max   = '1;

   logic [SHOT_W-1:0] shots_q, shots_d;
   logic [1:0]        big_left_q, big_left_d;
   logic [HIT_W-1:0]  hits_q, hits_d;

   always_comb begin
      shots_d    = shots_q;
      big_left_d = big_left_q;
      hits_d     = hits_q;
      if (load) begin
         shots_d    = c_shots_init;
         big_left_d = c_big_init;
         hits_d     = '0;
      end else if (consume) begin
         if (shots_q != '0)
            shots_d = shots_q - SHOT_W'(1);
         if (big && (big_left_q != 2'd0))
            big_left_d = big_left_q - 2'd1;
         if (hit && (hits_q != c_hits_max))
            hits_d = hits_q + HIT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_N) begin
      if (!reset_N) begin
         shots_q    <= '0;
         big_left_q <= 2'd0;
         hits_q     <= '0;
      end else begin
         shots_q    <= shots_d;
         big_left_q <= big_left_d;
         hits_q     <= hits_d;
      end
   end

   // The *_nxt views let the controller decide game end in the same cycle as the update.
   assign zero     = (shots_q == '0);
   assign zero_nxt = (shots_d == '0);
   assign big_left = big_left_q;
   assign hits     = hits_q;
   assign hits_nxt = hits_d;

endmodule
`default_nettype wire

// File: rtl/battleship_turn_controller.sv
`default_nettype none
// ------------------------------------------------------------------
// battleship_turn_controller: alternates two players over one shared scorer
// Revision: 1.0
// ------------------------------------------------------------------
module battleship_turn_controller
   import battleship_pkg::*;
#(
   parameter int SHOTS_PER_PLAYER = 20,
   parameter int WIN_HITS         = 10,
   parameter int BIG_SHOTS        = 3
) (
   input  logic                 clock,
   input  logic                 reset_N,
   input  logic                 Start,
   input  logic [1:0]           ShotValid,
   input  logic [2*COORD_W-1:0] ShotX,
   input  logic [2*COORD_W-1:0] ShotY,
   input  logic [1:0]           ShotBig,
   output logic [1:0]           ShotReady,
   output logic [COORD_W-1:0]   ScX,
   output logic [COORD_W-1:0]   ScY,
   output logic                 ScBig,
   output logic [1:0]           ScBigLeft,
   output logic                 ScScoreThis,
   input  logic                 ScHit,
   input  logic                 ScNearMiss,
   input  logic                 ScMiss,
   input  logic                 ScWrong,
   output logic                 ResultValid,
   output logic                 ResultPlayer,
   output logic [1:0]           ResultCode,
   output logic [HIT_W-1:0]     Hits0,
   output logic [HIT_W-1:0]     Hits1,
   output logic                 CurPlayer,
   output logic                 GameOver,
   output logic [1:0]           Winner
);

   localparam logic [HIT_W-1:0] c_win_hits = HIT_W'(WIN_HITS);

   state_e               state_q, state_d;
   logic                 cur_q, cur_d;
   logic [1:0]           ready_q, ready_d;
   logic [COORD_W-1:0]   sc_x_q, sc_x_d, sc_y_q, sc_y_d;
   logic                 sc_big_q, sc_big_d;
   logic [1:0]           sc_big_left_q, sc_big_left_d;
   logic                 sc_score_q, sc_score_d;
   logic                 res_valid_q, res_valid_d;
   logic                 res_player_q, res_player_d;
   result_e              res_code_q, res_code_d;
   logic                 game_over_q, game_over_d;
   logic [1:0]           winner_q, winner_d;

   logic                 load;
   logic                 scored;
   logic [1:0]           consume;
   logic [1:0]           zero, zero_nxt;
   logic [1:0][1:0]      big_left;
   logic [1:0][HIT_W-1:0] hits, hits_nxt;
   logic                 sc_miss_unused;

   // A Miss flag carries no information beyond the absence of Hit/NearMiss/Wrong.
   assign sc_miss_unused = ScMiss;

   assign load    = ((state_q == ST_IDLE) || (state_q == ST_GAME_OVER)) && Start;
   assign scored  = (state_q == ST_REPORT) && (res_code_q != RES_WRONG);
   assign consume = {scored & cur_q, scored & ~cur_q};

   for (genvar p = 0; p < 2; p++) begin : g_budget
      battleship_player_budget #(
         .SHOTS_PER_PLAYER (SHOTS_PER_PLAYER),
         .BIG_SHOTS        (BIG_SHOTS)
      ) u_budget (
         .clock    (clock),
         .reset_N  (reset_N),
         .load     (load),
         .consume  (consume[p]),
         .big      (sc_big_q),
         .hit      (res_code_q == RES_HIT),
         .zero     (zero[p]),
         .zero_nxt (zero_nxt[p]),
         .big_left (big_left[p]),
         .hits     (hits[p]),
         .hits_nxt (hits_nxt[p])
      );
   end

   always_comb begin
      state_d       = state_q;
      cur_d         = cur_q;
      ready_d       = 2'b00;
      sc_x_d        = sc_x_q;
      sc_y_d        = sc_y_q;
      sc_big_d      = sc_big_q;
      sc_big_left_d = sc_big_left_q;
      res_player_d  = res_player_q;
      res_code_d    = res_code_q;
      winner_d      = winner_q;

      case (state_q)
         ST_IDLE, ST_GAME_OVER: begin
            if (Start) begin
               cur_d    = 1'b0;
               winner_d = WIN_NONE;
               state_d  = ST_WAIT_SHOT;
            end
         end
         ST_WAIT_SHOT: begin
            if (ShotValid[cur_q] && ready_q[cur_q]) begin
               sc_x_d        = cur_q ? ShotX[2*COORD_W-1:COORD_W] : ShotX[COORD_W-1:0];
               sc_y_d        = cur_q ? ShotY[2*COORD_W-1:COORD_W] : ShotY[COORD_W-1:0];
               sc_big_d      = ShotBig[cur_q];
               sc_big_left_d = big_left[cur_q];
               state_d       = ST_SCORE;
            end else if (zero[cur_q]) begin
               cur_d = ~cur_q;
            end
         end
         ST_SCORE: begin
            res_code_d   = classify(ScHit, ScNearMiss, ScWrong);
            res_player_d = cur_q;
            state_d      = ST_REPORT;
         end
         ST_REPORT: begin
            state_d = ST_WAIT_SHOT;
            if (res_code_q != RES_WRONG) begin
               cur_d = ~cur_q;
               if (hits_nxt[cur_q] >= c_win_hits) begin
                  state_d  = ST_GAME_OVER;
                  winner_d = cur_q ? WIN_P1 : WIN_P0;
               end else if (&zero_nxt) begin
                  state_d = ST_GAME_OVER;
                  if (hits_nxt[0] > hits_nxt[1])
                     winner_d = WIN_P0;
                  else if (hits_nxt[1] > hits_nxt[0])
                     winner_d = WIN_P1;
                  else
                     winner_d = WIN_DRAW;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are registered against the state being entered so they line up with it.
      sc_score_d  = (state_d == ST_SCORE);
      res_valid_d = (state_d == ST_REPORT);
      game_over_d = (state_d == ST_GAME_OVER);
      if (state_d == ST_WAIT_SHOT)
         ready_d = cur_d ? {~zero_nxt[1], 1'b0} : {1'b0, ~zero_nxt[0]};
   end

   always_ff @(posedge clock or negedge reset_N) begin
      if (!reset_N) begin
         state_q       <= ST_IDLE;
         cur_q         <= 1'b0;
         ready_q       <= 2'b00;
         sc_x_q        <= '0;
         sc_y_q        <= '0;
         sc_big_q      <= 1'b0;
         sc_big_left_q <= 2'd0;
         sc_score_q    <= 1'b0;
         res_valid_q   <= 1'b0;
         res_player_q  <= 1'b0;
         res_code_q    <= RES_MISS;
         game_over_q   <= 1'b0;
         winner_q      <= WIN_NONE;
      end else begin
         state_q       <= state_d;
         cur_q         <= cur_d;
         ready_q       <= ready_d;
         sc_x_q        <= sc_x_d;
         sc_y_q        <= sc_y_d;
         sc_big_q      <= sc_big_d;
         sc_big_left_q <= sc_big_left_d;
         sc_score_q    <= sc_score_d;
         res_valid_q   <= res_valid_d;
         res_player_q  <= res_player_d;
         res_code_q    <= res_code_d;
         game_over_q   <= game_over_d;
         winner_q      <= winner_d;
      end
   end

   assign ShotReady    = ready_q;
   assign ScX          = sc_x_q;
   assign ScY          = sc_y_q;
   assign ScBig        = sc_big_q;
   assign ScBigLeft    = sc_big_left_q;
   assign ScScoreThis  = sc_score_q;
   assign ResultValid  = res_valid_q;
   assign ResultPlayer = res_player_q;
   assign ResultCode   = res_code_q;
   assign Hits0        = hits[0];
   assign Hits1        = hits[1];
   assign CurPlayer    = cur_q;
   assign GameOver     = game_over_q;
   assign Winner       = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_battleship_turn_controller.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_battleship_turn_controller: directed self-checking bench
// Revision: 1.0
// ------------------------------------------------------------------
module tb_battleship_turn_controller;

   logic       clock;
   logic       reset_N;
   logic       Start;
   logic [1:0] ShotValid;
   logic [7:0] ShotX, ShotY;
   logic [1:0] ShotBig;
   logic [1:0] ShotReady;
   logic [3:0] ScX, ScY;
   logic       ScBig;
   logic [1:0] ScBigLeft;
   logic       ScScoreThis;
   logic       ScHit, ScNearMiss, ScMiss, ScWrong;
   logic       ResultValid, ResultPlayer;
   logic [1:0] ResultCode;
   logic [6:0] Hits0, Hits1;
   logic       CurPlayer, GameOver;
   logic [1:0] Winner;

   int checks = 0;
   int errors = 0;

   // Scorer flag patterns {Wrong, Hit, NearMiss, Miss}
   localparam logic [3:0] S_MISS  = 4'b0001;
   localparam logic [3:0] S_NEAR  = 4'b0010;
   localparam logic [3:0] S_HIT   = 4'b0100;
   localparam logic [3:0] S_WRONG = 4'b1000;

   battleship_turn_controller #(
      .SHOTS_PER_PLAYER (20),
      .WIN_HITS         (2),
      .BIG_SHOTS        (3)
   ) dut (
      .clock        (clock),
      .reset_N      (reset_N),
      .Start        (Start),
      .ShotValid    (ShotValid),
      .ShotX        (ShotX),
      .ShotY        (ShotY),
      .ShotBig      (ShotBig),
      .ShotReady    (ShotReady),
      .ScX          (ScX),
      .ScY          (ScY),
      .ScBig        (ScBig),
      .ScBigLeft    (ScBigLeft),
      .ScScoreThis  (ScScoreThis),
      .ScHit        (ScHit),
      .ScNearMiss   (ScNearMiss),
      .ScMiss       (ScMiss),
      .ScWrong      (ScWrong),
      .ResultValid  (ResultValid),
      .ResultPlayer (ResultPlayer),
      .ResultCode   (ResultCode),
      .Hits0        (Hits0),
      .Hits1        (Hits1),
      .CurPlayer    (CurPlayer),
      .GameOver     (GameOver),
      .Winner       (Winner)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      Start = 1'b1;
      @(posedge clock); #1;
      Start = 1'b0;
   endtask

   // One full shot: handshake, score cycle, report cycle, then one cycle after the report.
   task automatic fire(input int p, input logic [3:0] x, input logic [3:0] y, input logic big,
                       input logic [3:0] sc, input logic [1:0] exp_code, input logic [1:0] exp_bl);
      int n;
      ShotX   = '0;
      ShotY   = '0;
      ShotBig = '0;
      if (p == 0) begin
         ShotX[3:0] = x;  ShotY[3:0] = y;  ShotBig[0] = big;
      end else begin
         ShotX[7:4] = x;  ShotY[7:4] = y;  ShotBig[1] = big;
      end
      ShotValid = (p == 0) ? 2'b01 : 2'b10;
      {ScWrong, ScHit, ScNearMiss, ScMiss} = sc;
      n = 0;
      while ((ShotReady[p] !== 1'b1) && (n < 10)) begin
         @(posedge clock); #1;
         n++;
      end
      chk("ready_wait", 32'(n < 10), 1);
      @(posedge clock); #1;
      ShotValid = 2'b00;
      chk("score_strobe", ScScoreThis, 1);
      chk("sc_xy", {ScX, ScY}, {x, y});
      chk("sc_big", ScBig, big);
      chk("sc_bigleft", ScBigLeft, exp_bl);
      @(posedge clock); #1;
      chk("score_strobe_end", ScScoreThis, 0);
      chk("result_valid", ResultValid, 1);
      chk("result_code", ResultCode, exp_code);
      chk("result_player", ResultPlayer, p);
      @(posedge clock); #1;
      chk("result_pulse_end", ResultValid, 0);
   endtask

   initial begin
      reset_N   = 1'b0;
      Start     = 1'b0;
      ShotValid = 2'b00;
      ShotX     = '0;
      ShotY     = '0;
      ShotBig   = 2'b00;
      {ScWrong, ScHit, ScNearMiss, ScMiss} = 4'b0000;

      repeat (2) @(posedge clock);
      #1;
      chk("rst_ready", ShotReady, 2'b00);
      chk("rst_gameover", GameOver, 0);
      chk("rst_winner", Winner, 2'b00);
      chk("rst_hits", {Hits0, Hits1}, 0);
      chk("rst_cur", CurPlayer, 0);
      chk("rst_result_valid", ResultValid, 0);
      chk("rst_score", ScScoreThis, 0);
      reset_N = 1'b1;
      @(posedge clock); #1;

      // Reset arriving while a shot is being scored
      pulse_start();
      chk("start_ready", ShotReady, 2'b01);
      ShotX[3:0] = 4'd5;
      ShotY[3:0] = 4'd6;
      ShotValid  = 2'b01;
      @(posedge clock); #1;
      ShotValid = 2'b00;
      chk("pre_reset_score", ScScoreThis, 1);
      reset_N = 1'b0;
      #1;
      chk("midreset_score", ScScoreThis, 0);
      chk("midreset_scx", ScX, 0);
      chk("midreset_ready", ShotReady, 2'b00);
      chk("midreset_valid", ResultValid, 0);
      #1;
      reset_N = 1'b1;
      @(posedge clock); #1;
      chk("after_reset_valid", ResultValid, 0);
      chk("after_reset_idle", ShotReady, 2'b00);

      // Game 1 (WIN_HITS = 2)
      pulse_start();
      chk("g1_ready", ShotReady, 2'b01);
      chk("g1_hits", {Hits0, Hits1}, 0);
      chk("g1_cur", CurPlayer, 0);

      ShotValid = 2'b10;
      repeat (3) @(posedge clock);
      #1;
      chk("p1_ignored_ready", ShotReady, 2'b01);
      chk("p1_ignored_score", ScScoreThis, 0);
      ShotValid = 2'b00;

      fire(0, 4'd3, 4'd4, 1'b0, S_HIT, 2'b10, 2'd3);
      chk("hit_hits0", Hits0, 1);
      chk("hit_cur", CurPlayer, 1);
      chk("hit_ready", ShotReady, 2'b10);

      pulse_start();
      chk("midgame_start_hits0", Hits0, 1);
      chk("midgame_start_cur", CurPlayer, 1);
      chk("midgame_start_ready", ShotReady, 2'b10);

      fire(1, 4'd7, 4'd8, 1'b0, S_MISS, 2'b00, 2'd3);
      chk("miss_hits1", Hits1, 0);
      chk("miss_cur", CurPlayer, 0);

      fire(0, 4'd1, 4'd1, 1'b0, S_WRONG | S_HIT, 2'b11, 2'd3);
      chk("wrong_hits0", Hits0, 1);
      chk("wrong_cur", CurPlayer, 0);
      chk("wrong_ready", ShotReady, 2'b01);

      fire(0, 4'd1, 4'd2, 1'b0, S_NEAR, 2'b01, 2'd3);
      chk("near_cur", CurPlayer, 1);

      for (int k = 0; k < 3; k++) begin
         fire(1, 4'd0, 4'd0, 1'b0, S_MISS, 2'b00, 2'd3);
         fire(0, 4'(k), 4'(k), 1'b1, S_MISS, 2'b00, 2'(3 - k));
      end
      fire(1, 4'd0, 4'd0, 1'b0, S_MISS, 2'b00, 2'd3);
      fire(0, 4'd9, 4'd9, 1'b1, S_WRONG, 2'b11, 2'd0);
      chk("big4_cur", CurPlayer, 0);
      chk("big4_hits0", Hits0, 1);

      fire(0, 4'd2, 4'd3, 1'b0, S_HIT | S_MISS, 2'b10, 2'd0);
      chk("win_gameover", GameOver, 1);
      chk("win_winner", Winner, 2'b01);
      chk("win_hits0", Hits0, 2);
      chk("win_ready", ShotReady, 2'b00);
      ShotValid = 2'b11;
      repeat (2) @(posedge clock);
      #1;
      ShotValid = 2'b00;
      chk("over_no_score", ScScoreThis, 0);
      chk("over_winner_hold", Winner, 2'b01);
      chk("over_hits_hold", Hits0, 2);

      // Game 2: ammunition runs out, player1 ahead by one hit
      pulse_start();
      chk("g2_gameover", GameOver, 0);
      chk("g2_winner", Winner, 2'b00);
      chk("g2_hits0", Hits0, 0);
      chk("g2_ready", ShotReady, 2'b01);
      for (int i = 0; i < 20; i++) begin
         fire(0, 4'(i), 4'd0, 1'b0, S_MISS, 2'b00, 2'd3);
         if (i == 19) begin
            chk("g2_last_ready", ShotReady, 2'b10);
            chk("g2_not_over", GameOver, 0);
         end
         if (i == 0)
            fire(1, 4'd0, 4'(i), 1'b0, S_HIT, 2'b10, 2'd3);
         else
            fire(1, 4'd0, 4'(i), 1'b0, S_MISS, 2'b00, 2'd3);
      end
      chk("g2_gameover_end", GameOver, 1);
      chk("g2_winner_end", Winner, 2'b10);
      chk("g2_hits", {Hits0, Hits1}, {7'd0, 7'd1});

      // Game 3: ammunition runs out with equal hits
      pulse_start();
      for (int i = 0; i < 20; i++) begin
         if (i == 0)
            fire(0, 4'd1, 4'd1, 1'b0, S_HIT, 2'b10, 2'd3);
         else
            fire(0, 4'd1, 4'd1, 1'b0, S_NEAR, 2'b01, 2'd3);
         if (i == 5)
            fire(1, 4'd2, 4'd2, 1'b0, S_HIT, 2'b10, 2'd3);
         else
            fire(1, 4'd2, 4'd2, 1'b0, S_MISS, 2'b00, 2'd3);
      end
      chk("g3_gameover", GameOver, 1);
      chk("g3_winner_draw", Winner, 2'b11);
      chk("g3_hits", {Hits0, Hits1}, {7'd1, 7'd1});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/battleship_turn_controller.md
Name: battleship_turn_controller

Overview:
- Sequences one shared combinational Battleship scorer between two players who take alternating turns.
- Accepts shots from each player over a valid/ready handshake and drives the scorer's X/Y/Big/BigLeft/ScoreThis inputs for exactly one cycle per shot.
- Captures Hit/NearMiss/Miss/SomethingIsWrong, keeps per-player hit, shot and big-shot budgets, and declares the winner.
- Sits between the player input front-ends and the scorer instance.

Parameters:
- SHOTS_PER_PLAYER, 20, legal shots each player may fire before being out of ammunition.
- WIN_HITS, 10, hit count at which a player wins immediately.
- BIG_SHOTS, 3, initial BigLeft budget per player; must be ≤ 3.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset_N  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle pulse; starts a new game from IDLE or GAME_OVER.
- ShotValid  in  2  per-player shot request; bit p belongs to player p.
- ShotX  in  2x4  per-player column; packed, player p at [4p+3:4p].
- ShotY  in  2x4  per-player row; same packing.
- ShotBig  in  2  per-player big-shot request.
- ShotReady  out  2  one-hot ready; only the current player's bit may be 1.
- ScX, ScY  out  4 each  scorer coordinates, registered.
- ScBig  out  1  scorer Big.
- ScBigLeft  out  2  current player's remaining big shots.
- ScScoreThis  out  1  one-cycle score strobe.
- ScHit, ScNearMiss, ScMiss, ScWrong  in  1 each  scorer results; combinational from Sc* outputs.
- ResultValid  out  1  one-cycle pulse per scored shot.
- ResultPlayer  out  1  player who fired.
- ResultCode  out  2  00 Miss, 01 NearMiss, 10 Hit, 11 Wrong (rejected).
- Hits0, Hits1  out  7 each  per-player hit counts.
- CurPlayer  out  1  whose turn it is.
- GameOver  out  1  high in GAME_OVER.
- Winner  out  2  00 none, 01 player0, 10 player1, 11 draw.

Behaviour:
- Reset (async, reset_N = 0) forces:
  - State IDLE.
  - ShotReady, ScScoreThis, ResultValid and GameOver = 0.
  - All counters = 0; CurPlayer = 0; Winner = 00.
  - Sc* and Result* outputs = 0.
  - A reset mid-game abandons the game with no result pulse.
- States are IDLE, WAIT_SHOT, SCORE, REPORT and GAME_OVER.
- IDLE:
  - Start moves to WAIT_SHOT.
  - Hits cleared, shot counters loaded to SHOTS_PER_PLAYER, BigLeft loaded to BIG_SHOTS, CurPlayer = 0, Winner = 00.
- WAIT_SHOT:
  - ShotReady[CurPlayer] = 1; the other bit is 0.
  - ShotValid from the non-current player is ignored and does not stall it.
  - On ShotValid[CurPlayer] && ShotReady, latch X, Y and Big into Sc*, then go to SCORE.
  - If the current player has zero shots left, ShotReady stays 0 and the turn passes to the other player.
- SCORE (one cycle):
  - ScScoreThis = 1 and ScBigLeft = the current player's BigLeft.
  - Scorer outputs are sampled at the end of this cycle; then go to REPORT.
- REPORT (one cycle):
  - ResultValid = 1 with the captured code.
  - If Wrong: no counter changes and CurPlayer is unchanged, so the player retries.
  - Otherwise:
    - Decrement the player's shot count.
    - If Big, decrement BigLeft; it saturates at 0, but a Big shot with BigLeft = 0 is a scorer Wrong.
    - On a Hit, increment Hits with saturation at 127.
    - Toggle CurPlayer.
  - Priority when leaving REPORT:
    - Go to GAME_OVER if the updated Hits of the shooter ≥ WIN_HITS; Winner = shooter.
    - Otherwise go to GAME_OVER if both players have zero shots left; Winner is the higher Hits, or 11 when equal.
    - Otherwise return to WAIT_SHOT.
- Latency: 3 cycles from accepted handshake to ResultValid; at most one shot is in flight at a time.
- GAME_OVER:
  - GameOver = 1; Hits and Winner hold.
  - Start restarts the game; a Start arriving mid-game is ignored.
- Precedence: Hit and Miss from the scorer both asserted counts as Hit; Wrong overrides all other results.

Decomposition:
- Shared package battleship_pkg holds:
  - The state enum.
  - The ResultCode enum (RES_MISS, RES_NEAR, RES_HIT, RES_WRONG).
  - The Winner encoding.
  - Width constants: coordinate width 4, hit width 7.
- One natural sub-module, battleship_player_budget, instantiated twice, holds per-player state.
  - State: shot counter, BigLeft and Hits.
  - Controls: load, consume, big and hit strobes.
  - Outputs: zero flag, BigLeft and Hits.

Test Plan:
- Reset mid-SCORE → next cycle all outputs 0, state IDLE; a later Start gives a clean game with Hits0 = Hits1 = 0.
- Start; player0 shoots (3,4) while the scorer returns Hit → ScScoreThis pulses 2 cycles after the handshake, ResultValid with code 10 at 3 cycles, Hits0 = 1, CurPlayer = 1.
- Player1 asserts ShotValid during player0's turn → ShotReady[1] stays 0 and no score strobe occurs until player0 has fired.
- Scorer returns Wrong for player0 → code 11, counters unchanged, CurPlayer stays 0, and player0's retry is accepted.
- Player0 fires 4 Big shots with BIG_SHOTS = 3 → ScBigLeft reads 3, 2, 1, then 0 on the fourth shot, and the Wrong returned for it is reported.
- WIN_HITS = 2: player0 hits twice → GameOver = 1 and Winner = 01 after the second REPORT. SHOTS_PER_PLAYER = 1 with two misses → Winner = 11.
